reaction_ctrl: RTL and testbench
================================

// Module: reaction_ctrl
// PURPOSE
//  Reaction-test sequencer that drives the 16-bit Counter's enable/clear control interface and consumes its count/carry_out.
//  Waits a pseudo-random delay, lights the stimulus LED, measures press latency in ms via Counter, and reports result/flags.
//  Sits between the debounced button front-end and the display/result logic.
// PARAMETERS
//  CLK_PER_MS   100000   clk cycles per ms tick (100 MHz clk)
//  MIN_DELAY_MS 1000     fixed part of the pre-stimulus delay, ms
//  DELAY_BITS   12       random part = LFSR[DELAY_BITS-1:0] ms (0..4095)
//  TIMEOUT_MS   9999     no-press limit, ms (must be < 65535)
//  LFSR_SEED    16'hACE1 LFSR reset value (non-zero)
// PORTS
//  clk          in   1   system clock
//  rstn         in   1   async active-low reset
//  start_btn    in   1   1-cycle start pulse (debounced upstream)
//  react_btn    in   1   1-cycle reaction pulse (debounced upstream)
//  cnt_count    in   16  Counter count output
//  cnt_carry    in   1   Counter carry_out
//  cnt_enable   out  1   Counter enable; high for exactly 1 cycle per ms tick in STIM only
//  cnt_clear    out  1   Counter sync clear; 1-cycle pulse on accepted start
//  led_stim     out  1   stimulus LED
//  busy         out  1   high in ARM and STIM
//  result_ms    out  16  latched reaction time, ms
//  result_valid out  1   1-cycle pulse when result_ms/flags update
//  too_early    out  1   sticky: press during ARM
//  timeout      out  1   sticky: no press within TIMEOUT_MS
// BEHAVIOUR
//  Reset (async): state IDLE, LFSR=LFSR_SEED, prescaler=0, all outputs 0, result_ms=0; mid-run reset drops led_stim at once.
//  Prescaler: counts 0..CLK_PER_MS-1, ms_tick when value==CLK_PER_MS-1; forced to 0 on accepted start.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk (free-running, so start timing gives the entropy).
//  States (registered): IDLE -> ARM -> STIM -> DONE; DONE behaves as IDLE for start.
//   IDLE/DONE: start_btn -> cnt_clear=1 for that cycle, clear too_early/timeout, delay <= MIN_DELAY_MS + LFSR[DELAY_BITS-1:0], -> ARM.
//   ARM: each ms_tick delay--; tick with delay==1 -> STIM, led_stim=1 next cycle. react_btn -> too_early=1, result_ms=0, result_valid, -> DONE.
//   STIM: cnt_enable=ms_tick. react_btn -> result_ms=cnt_count (that cycle), result_valid, led_stim=0, -> DONE.
//   STIM: cnt_count==TIMEOUT_MS or cnt_carry -> timeout=1, result_ms=16'hFFFF, result_valid, led_stim=0, -> DONE.
//  Count semantics: Counter is zero at led rise; result_ms = number of ms ticks elapsed since led_stim rose.
//  Priorities/boundaries:
//   - ARM: react_btn same cycle as delay expiry -> too_early wins.
//   - STIM: react_btn same cycle as ms_tick -> pre-increment cnt_count used.
//   - STIM: react_btn same cycle as timeout -> react wins.
//   - start_btn ignored while busy; react_btn ignored in IDLE/DONE.
//  Widths: delay register DELAY_BITS+1 bits min, sized by package constant; no wrap in ARM (delay>=MIN_DELAY_MS>=1).
// CONFIGURATION
//  REACT_BEST_HOLD_EN defined: adds out best_ms[15:0] (reset 16'hFFFF) = min of all valid (non-early, non-timeout) results; updated with result_valid.
//  Not defined: best_ms port and logic absent; all else identical.
// STRUCTURE
//  Package reaction_pkg: state enum (IDLE, ARM, STIM, DONE), LFSR tap mask, RESULT_TIMEOUT=16'hFFFF, delay-width function.
//  Sub-module lfsr16 (clk, rstn, seed param, q[15:0]); prescaler and FSM stay in reaction_ctrl.
//  Instantiated beside Counter; cnt_* ports wire directly to it.
// TESTING (bench params CLK_PER_MS=10, MIN_DELAY_MS=5, DELAY_BITS=3, TIMEOUT_MS=50, real Counter instance)
//  1. rstn=0 then release -> all outputs 0, result_ms=0, state IDLE, no cnt_clear.
//  2. start, react 250 clks (25 ticks) after led_stim rise -> result_ms=25, 1-cycle result_valid, led_stim=0, flags 0.
//  3. start, react 2 ticks later (ARM) -> too_early=1, result_ms=0, led_stim never 1, cnt_enable never 1.
//  4. start, no react -> 50 ticks after led rise timeout=1, result_ms=16'hFFFF, led_stim=0; delay in 5..12 ticks.
//  5. start while busy ignored; rstn pulse mid-STIM -> led_stim=0 immediately, IDLE; next start runs normally.
//  6. REACT_BEST_HOLD_EN: results 30, 20, early, 25 -> best_ms 30, 20, 20, 20; without macro, port absent, results match.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-test sequencer.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    STIM = 2'd2,
    DONE = 2'd3
  } state_e;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] RESULT_TIMEOUT = 16'hFFFF;

  // Width that holds min_ms + (2**bits - 1), never less than bits+1.
  function automatic int delay_width(input int min_ms, input int bits);
    int w;
    w = $clog2(min_ms + (1 << bits));
    return (w > bits + 1) ? w : bits + 1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every clock.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= SEED;
    else       q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-test sequencer: random pre-delay, stimulus LED, latency capture via external Counter.
// Optional REACT_BEST_HOLD_EN adds best_ms, the minimum of all valid reaction results.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int          CLK_PER_MS   = 100000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          DELAY_BITS   = 12,
  parameter int          TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic [15:0] cnt_count,
  input  logic        cnt_carry,
  output logic        cnt_enable,
  output logic        cnt_clear,
  output logic        led_stim,
  output logic        busy,
  output logic [15:0] result_ms,
  output logic        result_valid,
  output logic        too_early,
  output logic        timeout
`ifdef REACT_BEST_HOLD_EN
  ,
  output logic [15:0] best_ms
`endif
);

  localparam int              DELAY_W     = delay_width(MIN_DELAY_MS, DELAY_BITS);
  localparam int              PS_W        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST     = PS_W'(CLK_PER_MS - 1);
  localparam logic [15:0]     TIMEOUT_CNT = 16'(TIMEOUT_MS);

  state_e             state;
  logic [PS_W-1:0]    prescale;
  logic [DELAY_W-1:0] delay;
  logic [15:0]        lfsr_q;
  logic               ms_tick;
  logic               accept_start;
  logic               stim_timeout;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .q    (lfsr_q)
  );

  assign accept_start = start_btn && ((state == IDLE) || (state == DONE));
  assign ms_tick      = (prescale == PS_LAST);
  assign stim_timeout = (cnt_count == TIMEOUT_CNT) || cnt_carry;
  assign cnt_clear    = accept_start;
  assign cnt_enable   = (state == STIM) && ms_tick;
  assign busy         = (state == ARM) || (state == STIM);

  // Restarting the prescaler on start aligns the first ARM tick to a full ms.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       prescale <= '0;
    else if (accept_start || ms_tick) prescale <= '0;
    else                             prescale <= prescale + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      delay        <= '0;
      led_stim     <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      too_early    <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_btn) begin
            too_early <= 1'b0;
            timeout   <= 1'b0;
            delay     <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[DELAY_BITS-1:0]);
            state     <= ARM;
          end
        end
        ARM: begin
          // An early press beats a delay expiry in the same cycle.
          if (react_btn) begin
            too_early    <= 1'b1;
            result_ms    <= '0;
            result_valid <= 1'b1;
            state        <= DONE;
          end else if (ms_tick) begin
            delay <= delay - 1'b1;
            if (delay == DELAY_W'(1)) begin
              state    <= STIM;
              led_stim <= 1'b1;
            end
          end
        end
        STIM: begin
          // A press beats a timeout; cnt_count is still the pre-tick value here.
          if (react_btn) begin
            result_ms    <= cnt_count;
            result_valid <= 1'b1;
            led_stim     <= 1'b0;
            state        <= DONE;
          end else if (stim_timeout) begin
            timeout      <= 1'b1;
            result_ms    <= RESULT_TIMEOUT;
            result_valid <= 1'b1;
            led_stim     <= 1'b0;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REACT_BEST_HOLD_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      best_ms <= RESULT_TIMEOUT;
    else if ((state == STIM) && react_btn && (cnt_count < best_ms))
      best_ms <= cnt_count;
  end
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with a small enable/clear Counter model.
// Expected timing is derived from tick arithmetic; the pre-delay uses a reference LFSR.
module tb_reaction_ctrl;

  localparam int CPM = 10;
  localparam int MIN = 5;
  localparam int DB  = 3;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rstn, start_btn, react_btn;
  logic [15:0] cnt_count;
  logic        cnt_carry, cnt_enable, cnt_clear, led_stim, busy;
  logic [15:0] result_ms;
  logic        result_valid, too_early, timeout;
`ifdef REACT_BEST_HOLD_EN
  logic [15:0] best_ms;
`endif

  int total = 0;
  int bad   = 0;
  int en_err = 0;
  logic [15:0] m_lfsr;
  int          m_best;

  typedef struct {
    int mode;     // 0 react after led rise, 1 react in ARM, 2 no react, 3 react on expiry tick
    int param;    // mode 0: cycles after rise; mode 1: ticks after start
    bit extra;    // extra start pulse while busy
    int exp_res;
    bit exp_early;
    bit exp_to;
  } rec_t;

  rec_t tbl[12];

  reaction_ctrl #(
    .CLK_PER_MS(CPM), .MIN_DELAY_MS(MIN), .DELAY_BITS(DB),
    .TIMEOUT_MS(TMO), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rstn(rstn), .start_btn(start_btn), .react_btn(react_btn),
    .cnt_count(cnt_count), .cnt_carry(cnt_carry), .cnt_enable(cnt_enable),
    .cnt_clear(cnt_clear), .led_stim(led_stim), .busy(busy),
    .result_ms(result_ms), .result_valid(result_valid),
    .too_early(too_early), .timeout(timeout)
`ifdef REACT_BEST_HOLD_EN
    , .best_ms(best_ms)
`endif
  );

  always #5 clk = ~clk;

  // Counter: sync clear, count on enable, carry on wrap
  always @(posedge clk or negedge rstn) begin
    if (!rstn)           cnt_count <= 16'd0;
    else if (cnt_clear)  cnt_count <= 16'd0;
    else if (cnt_enable) cnt_count <= cnt_count + 16'd1;
  end
  assign cnt_carry = cnt_enable && (cnt_count == 16'hFFFF);

  // Reference LFSR, x^16+x^14+x^13+x^11 feedback into bit 0
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge clk) if (rstn && cnt_enable && !led_stim) en_err++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic run(input rec_t r);
    int d, n, target;
    bit seen;
    d = MIN + int'(m_lfsr[DB-1:0]);
    seen = 0;
    start_btn = 1'b1;
    #1 chk("cnt_clear_on_start", int'(cnt_clear), 1);
    @(negedge clk);
    start_btn = 1'b0;
    n = 1;
    if (r.mode == 1 || r.mode == 3) begin
      target = (r.mode == 1) ? r.param * CPM : d * CPM;
      while (n < target) begin
        @(negedge clk); n++;
        if (led_stim || cnt_enable) seen = 1;
      end
      react_btn = 1'b1;
      @(negedge clk);
      react_btn = 1'b0;
      chk("early_valid", int'(result_valid), 1);
      chk("early_result", int'(result_ms), 0);
      chk("early_flag", int'(too_early), 1);
      chk("early_timeout", int'(timeout), 0);
      chk("early_led_never", int'(seen | led_stim), 0);
    end else begin
      while (!led_stim && n < 200) begin
        start_btn = (r.extra && n == 30);
        #1 if (start_btn) chk("busy_start_ignored", int'(cnt_clear), 0);
        @(negedge clk); n++;
      end
      start_btn = 1'b0;
      chk("led_rise_cycle", n, d * CPM + 1);
      if (r.mode == 0) begin
        repeat (r.param) @(negedge clk);
        react_btn = 1'b1;
        @(negedge clk);
        react_btn = 1'b0;
      end else begin
        n = 0;
        while (!result_valid && n < 700) begin @(negedge clk); n++; end
        chk("timeout_cycle", n, TMO * CPM + 1);
      end
      chk("res_valid", int'(result_valid), 1);
      chk("res_value", int'(result_ms), r.exp_res);
      chk("res_timeout", int'(timeout), int'(r.exp_to));
      chk("res_early", int'(too_early), 0);
      chk("res_led_off", int'(led_stim), 0);
      if (r.mode == 0 && r.exp_res < m_best) m_best = r.exp_res;
    end
`ifdef REACT_BEST_HOLD_EN
    chk("best_ms", int'(best_ms), m_best);
`endif
    @(negedge clk);
    chk("valid_one_cycle", int'(result_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=expired required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t rr;
    tbl[0]  = '{0, 300, 0, 30, 0, 0};
    tbl[1]  = '{0, 200, 0, 20, 0, 0};
    tbl[2]  = '{1, 2,   0, 0,  1, 0};
    tbl[3]  = '{0, 250, 0, 25, 0, 0};
    tbl[4]  = '{0, 9,   0, 0,  0, 0};
    tbl[5]  = '{0, 10,  0, 1,  0, 0};
    tbl[6]  = '{0, 0,   0, 0,  0, 0};
    tbl[7]  = '{0, 500, 0, 50, 0, 0};
    tbl[8]  = '{0, 499, 0, 49, 0, 0};
    tbl[9]  = '{2, 0,   0, 65535, 0, 1};
    tbl[10] = '{3, 0,   0, 0,  1, 0};
    tbl[11] = '{0, 120, 1, 12, 0, 0};
    m_best = 65535;

    rstn = 1'b0; start_btn = 1'b0; react_btn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_led", int'(led_stim), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result_ms), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_flags", int'({too_early, timeout}), 0);
    chk("rst_cnt_ctrl", int'({cnt_enable, cnt_clear}), 0);
`ifdef REACT_BEST_HOLD_EN
    chk("rst_best", int'(best_ms), 65535);
`endif

    for (int i = 0; i < 12; i++) begin
      run(tbl[i]);
      repeat (3) @(negedge clk);
    end

    // Reset while the stimulus is lit, then a normal run.
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    for (int k = 0; k < 200 && !led_stim; k++) @(negedge clk);
    chk("mid_led_up", int'(led_stim), 1);
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_led", int'(led_stim), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    m_best = 65535;
    @(negedge clk);
    run(tbl[3]);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      rr.mode  = int'($urandom_range(0, 1));
      rr.extra = 1'b0;
      rr.exp_to = 1'b0;
      if (rr.mode == 0) begin
        rr.param     = int'($urandom_range(0, 500));
        rr.exp_res   = rr.param / CPM;
        rr.exp_early = 1'b0;
      end else begin
        rr.param     = int'($urandom_range(1, MIN - 1));
        rr.exp_res   = 0;
        rr.exp_early = 1'b1;
      end
      run(rr);
    end

    chk("enable_outside_stim", en_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
